// File: rtl/ipv4_vlg_tx_buf_if.sv
// Bundle between the transport-layer producer, the payload buffer and the IPv4
// transmitter. "master" is the producer/transmitter side; "slave" is the buffer.
interface ipv4_vlg_tx_buf_if;
    // producer -> buffer
    logic        in_val;
    logic        in_sof;
    logic        in_eof;
    logic [7:0]  in_dat;
    logic [31:0] in_dst_ip;
    logic [7:0]  in_proto;
    logic        in_mac_known;
    logic [47:0] in_dst_mac;
    logic        in_rdy;
    logic [31:0] dev_ipv4_addr;
    // buffer <-> transmitter
    logic        tx_rdy;
    logic        tx_acc;
    logic        tx_req;
    logic [7:0]  tx_dat;
    logic        tx_done;
    logic [15:0] tx_pld_len;
    logic [31:0] tx_src_ip;
    logic [31:0] tx_dst_ip;
    logic [7:0]  tx_proto;
    logic [15:0] tx_id;
    logic [7:0]  tx_ttl;
    logic        tx_df;
    logic        tx_mac_known;
    logic [47:0] tx_dst_mac;
    logic        drop;

    modport master (
        output in_val, in_sof, in_eof, in_dat, in_dst_ip, in_proto, in_mac_known,
               in_dst_mac, dev_ipv4_addr, tx_acc, tx_req, tx_done,
        input  in_rdy, tx_rdy, tx_dat, tx_pld_len, tx_src_ip, tx_dst_ip, tx_proto,
               tx_id, tx_ttl, tx_df, tx_mac_known, tx_dst_mac, drop
    );

    modport slave (
        input  in_val, in_sof, in_eof, in_dat, in_dst_ip, in_proto, in_mac_known,
               in_dst_mac, dev_ipv4_addr, tx_acc, tx_req, tx_done,
        output in_rdy, tx_rdy, tx_dat, tx_pld_len, tx_src_ip, tx_dst_ip, tx_proto,
               tx_id, tx_ttl, tx_df, tx_mac_known, tx_dst_mac, drop
    );
endinterface

// File: rtl/ipv4_vlg_tx_buf.sv
// Store-and-forward payload buffer in front of the IPv4 transmitter. A whole
// packet is written into a byte RAM, offered with its metadata via tx_rdy/tx_acc,
// then replayed REQ_LAT cycles after the transmitter first raises tx_req.
// REQ_LAT must be at least 2.
module ipv4_vlg_tx_buf #(
    parameter int unsigned ADDR_W  = 11,
    parameter int unsigned REQ_LAT = 3,
    parameter logic [7:0]  TTL     = 8'd64
) (
    input logic              clk,
    input logic              rst,
    ipv4_vlg_tx_buf_if.slave bus
);

    // Pointers carry one extra bit so a completely full RAM (2**ADDR_W) is representable.
    localparam logic [ADDR_W:0] DEPTH   = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] PTR_ONE = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [7:0]      LAT_CNT = 8'(REQ_LAT - 2);

    typedef enum logic [2:0] {
        StIdle,
        StFill,
        StPend,
        StWaitReq,
        StRead,
        StWaitDone
    } state_t;

    state_t            state_q;
    logic [ADDR_W:0]   wptr_q;
    logic [ADDR_W:0]   rptr_q;
    logic [7:0]        lat_cnt_q;
    logic [7:0]        ram [0:(1 << ADDR_W) - 1];

    logic              tx_rdy_q;
    logic [7:0]        tx_dat_q;
    logic [15:0]       tx_pld_len_q;
    logic [31:0]       tx_src_ip_q;
    logic [31:0]       tx_dst_ip_q;
    logic [7:0]        tx_proto_q;
    logic [15:0]       tx_id_q;
    logic [7:0]        tx_ttl_q;
    logic              tx_df_q;
    logic              tx_mac_known_q;
    logic [47:0]       tx_dst_mac_q;
    logic              drop_q;

    logic              sof_hit;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic              rd_en;
    logic              rd_last;

    // Write-port decode, read issue and last-byte detection.
    always_comb begin
        sof_hit = bus.in_val && bus.in_sof && (state_q == StIdle || state_q == StFill);
        wr_en   = 1'b0;
        wr_addr = '0;
        if (sof_hit) begin
            wr_en   = 1'b1;
            wr_addr = '0;
        end else if (state_q == StFill && bus.in_val && wptr_q != DEPTH) begin
            wr_en   = 1'b1;
            wr_addr = wptr_q[ADDR_W-1:0];
        end
        // An abort on tx_done suppresses the read so tx_dat returns to 0 with the state.
        rd_en   = (state_q == StRead) && (lat_cnt_q == 8'd0) && !bus.tx_done;
        rd_last = (16'(rptr_q) == tx_pld_len_q - 16'd1);
    end

    // Payload RAM write port; contents need no reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            ram[wr_addr] <= bus.in_dat;
        end
    end

    // Control FSM with registered metadata, payload read and drop pulse.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q        <= StIdle;
            wptr_q         <= '0;
            rptr_q         <= '0;
            lat_cnt_q      <= 8'd0;
            tx_rdy_q       <= 1'b0;
            tx_dat_q       <= 8'h00;
            tx_pld_len_q   <= 16'd0;
            tx_src_ip_q    <= 32'd0;
            tx_dst_ip_q    <= 32'd0;
            tx_proto_q     <= 8'd0;
            tx_id_q        <= 16'd0;
            tx_ttl_q       <= 8'd0;
            tx_df_q        <= 1'b0;
            tx_mac_known_q <= 1'b0;
            tx_dst_mac_q   <= 48'd0;
            drop_q         <= 1'b0;
        end else begin
            drop_q   <= 1'b0;
            tx_dat_q <= rd_en ? ram[rptr_q[ADDR_W-1:0]] : 8'h00;

            if (sof_hit) begin
                // New packet; a sof while filling discards the partial one.
                drop_q         <= (state_q == StFill);
                tx_src_ip_q    <= bus.dev_ipv4_addr;
                tx_dst_ip_q    <= bus.in_dst_ip;
                tx_proto_q     <= bus.in_proto;
                tx_ttl_q       <= TTL;
                tx_df_q        <= 1'b1;
                tx_mac_known_q <= bus.in_mac_known;
                tx_dst_mac_q   <= bus.in_dst_mac;
                wptr_q         <= PTR_ONE;
                if (bus.in_eof) begin
                    tx_pld_len_q <= 16'd1;
                    tx_rdy_q     <= 1'b1;
                    state_q      <= StPend;
                end else begin
                    state_q      <= StFill;
                end
            end else begin
                case (state_q)
                    StIdle: begin
                    end
                    StFill: begin
                        if (bus.in_val) begin
                            if (wptr_q == DEPTH) begin
                                drop_q  <= 1'b1;
                                state_q <= StIdle;
                            end else begin
                                wptr_q <= wptr_q + PTR_ONE;
                                if (bus.in_eof) begin
                                    tx_pld_len_q <= 16'(wptr_q) + 16'd1;
                                    tx_rdy_q     <= 1'b1;
                                    state_q      <= StPend;
                                end
                            end
                        end
                    end
                    StPend: begin
                        if (bus.tx_done) begin
                            tx_rdy_q <= 1'b0;
                            state_q  <= StIdle;
                        end else if (bus.tx_acc) begin
                            tx_rdy_q <= 1'b0;
                            tx_id_q  <= tx_id_q + 16'd1;
                            state_q  <= StWaitReq;
                        end
                    end
                    StWaitReq: begin
                        if (bus.tx_done) begin
                            state_q <= StIdle;
                        end else if (bus.tx_req) begin
                            lat_cnt_q <= LAT_CNT;
                            rptr_q    <= '0;
                            state_q   <= StRead;
                        end
                    end
                    StRead: begin
                        if (bus.tx_done) begin
                            state_q <= StIdle;
                        end else if (lat_cnt_q != 8'd0) begin
                            lat_cnt_q <= lat_cnt_q - 8'd1;
                        end else begin
                            rptr_q <= rptr_q + PTR_ONE;
                            if (rd_last) begin
                                state_q <= StWaitDone;
                            end
                        end
                    end
                    StWaitDone: begin
                        if (bus.tx_done) begin
                            state_q <= StIdle;
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    assign bus.in_rdy       = (state_q == StIdle) || (state_q == StFill);
    assign bus.tx_rdy       = tx_rdy_q;
    assign bus.tx_dat       = tx_dat_q;
    assign bus.tx_pld_len   = tx_pld_len_q;
    assign bus.tx_src_ip    = tx_src_ip_q;
    assign bus.tx_dst_ip    = tx_dst_ip_q;
    assign bus.tx_proto     = tx_proto_q;
    assign bus.tx_id        = tx_id_q;
    assign bus.tx_ttl       = tx_ttl_q;
    assign bus.tx_df        = tx_df_q;
    assign bus.tx_mac_known = tx_mac_known_q;
    assign bus.tx_dst_mac   = tx_dst_mac_q;
    assign bus.drop         = drop_q;

endmodule

// File: tb/tb_ipv4_vlg_tx_buf.sv
// Directed bench for ipv4_vlg_tx_buf: a default-size instance for the data path
// and a 16-byte instance for the overflow boundary. Expected bytes are queued as
// they are driven and popped as they appear on tx_dat.
`timescale 1ns/1ps
module tb_ipv4_vlg_tx_buf;
    localparam int unsigned REQ_LAT = 3;
    localparam logic [31:0] DEV_IP  = 32'hC0A8_0001;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    ipv4_vlg_tx_buf_if if_a ();
    ipv4_vlg_tx_buf_if if_b ();

    ipv4_vlg_tx_buf #(.ADDR_W(11), .REQ_LAT(REQ_LAT), .TTL(8'd64)) dut (
        .clk (clk),
        .rst (rst),
        .bus (if_a)
    );

    ipv4_vlg_tx_buf #(.ADDR_W(4), .REQ_LAT(REQ_LAT), .TTL(8'd64)) dut_s (
        .clk (clk),
        .rst (rst),
        .bus (if_b)
    );

    int          n_pass = 0;
    int          n_total = 0;
    int          drop_cnt_a = 0;
    int          drops0;
    logic [7:0]  exp_q[$];
    logic [15:0] exp_id;

    always @(negedge clk) if (if_a.drop === 1'b1) drop_cnt_a++;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout required completion");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    endtask

    task automatic put_a(input logic sof, input logic eof, input logic [7:0] dat);
        if_a.in_val = 1'b1; if_a.in_sof = sof; if_a.in_eof = eof; if_a.in_dat = dat;
        @(negedge clk);
        if_a.in_val = 1'b0; if_a.in_sof = 1'b0; if_a.in_eof = 1'b0; if_a.in_dat = 8'h00;
    endtask

    task automatic put_b(input logic sof, input logic eof, input logic [7:0] dat);
        if_b.in_val = 1'b1; if_b.in_sof = sof; if_b.in_eof = eof; if_b.in_dat = dat;
        @(negedge clk);
        if_b.in_val = 1'b0; if_b.in_sof = 1'b0; if_b.in_eof = 1'b0; if_b.in_dat = 8'h00;
    endtask

    task automatic send_a(input logic [31:0] dst, input logic [7:0] proto,
                          input logic [47:0] mac, input int n, input logic [7:0] base);
        if_a.in_dst_ip = dst; if_a.in_proto = proto;
        if_a.in_mac_known = 1'b1; if_a.in_dst_mac = mac;
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(base + 8'(i));
            put_a(i == 0, i == n - 1, base + 8'(i));
        end
    endtask

    task automatic expect_pend(input int n, input logic [31:0] dst, input logic [7:0] proto,
                               input logic [47:0] mac);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 2; i++) begin
            if (if_a.tx_rdy === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("tx_rdy_after_eof", ok, 1);
        check("pld_len", if_a.tx_pld_len, n);
        check("id", if_a.tx_id, exp_id);
        check("dst_ip", if_a.tx_dst_ip, dst);
        check("src_ip", if_a.tx_src_ip, DEV_IP);
        check("proto", if_a.tx_proto, proto);
        check("ttl", if_a.tx_ttl, 64);
        check("df", if_a.tx_df, 1);
        check("mac_known", if_a.tx_mac_known, 1);
        check("dst_mac", if_a.tx_dst_mac, mac);
        check("pend_in_rdy", if_a.in_rdy, 0);
    endtask

    // Accept, request, compare the replay; abort_at >= 0 raises tx_done after that byte.
    task automatic run_tx(input int n, input int abort_at);
        check("q_size", exp_q.size(), n);
        if_a.tx_acc = 1'b1;
        @(negedge clk);
        if_a.tx_acc = 1'b0;
        exp_id = exp_id + 16'd1;
        check("acc_rdy_low", if_a.tx_rdy, 0);
        check("acc_id_inc", if_a.tx_id, exp_id);
        if_a.tx_req = 1'b1;
        for (int c = 1; c < REQ_LAT; c++) begin
            @(negedge clk);
            check("lat_zero", if_a.tx_dat, 0);
        end
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            check("tx_dat", if_a.tx_dat, exp_q.pop_front());
            if (k == abort_at) break;
        end
        if (abort_at >= 0) begin
            if_a.tx_done = 1'b1;
            @(negedge clk);
            if_a.tx_done = 1'b0; if_a.tx_req = 1'b0;
            check("abort_in_rdy", if_a.in_rdy, 1);
            check("abort_tx_rdy", if_a.tx_rdy, 0);
            check("abort_dat_zero", if_a.tx_dat, 0);
            check("abort_no_drop", if_a.drop, 0);
            exp_q.delete();
        end else begin
            @(negedge clk);
            check("tail_zero", if_a.tx_dat, 0);
            if_a.tx_req = 1'b0;
            if_a.tx_done = 1'b1;
            @(negedge clk);
            if_a.tx_done = 1'b0;
            check("done_in_rdy", if_a.in_rdy, 1);
        end
    endtask

    initial begin
        if_a.in_val = 0; if_a.in_sof = 0; if_a.in_eof = 0; if_a.in_dat = 0;
        if_a.in_dst_ip = 0; if_a.in_proto = 0; if_a.in_mac_known = 0; if_a.in_dst_mac = 0;
        if_a.dev_ipv4_addr = DEV_IP; if_a.tx_acc = 0; if_a.tx_req = 0; if_a.tx_done = 0;
        if_b.in_val = 0; if_b.in_sof = 0; if_b.in_eof = 0; if_b.in_dat = 0;
        if_b.in_dst_ip = 0; if_b.in_proto = 0; if_b.in_mac_known = 0; if_b.in_dst_mac = 0;
        if_b.dev_ipv4_addr = DEV_IP; if_b.tx_acc = 0; if_b.tx_req = 0; if_b.tx_done = 0;
        exp_id = 16'd0;

        // Reset state
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_in_rdy", if_a.in_rdy, 1);
        check("rst_tx_rdy", if_a.tx_rdy, 0);
        check("rst_tx_dat", if_a.tx_dat, 0);
        check("rst_drop", if_a.drop, 0);
        check("rst_id", if_a.tx_id, 0);
        check("rst_len", if_a.tx_pld_len, 0);
        check("rst_dst_ip", if_a.tx_dst_ip, 0);
        check("rst_src_ip", if_a.tx_src_ip, 0);
        check("rst_b_in_rdy", if_b.in_rdy, 1);
        check("rst_b_tx_rdy", if_b.tx_rdy, 0);
        rst = 1'b1;
        @(negedge clk);

        // 8-byte packet to 10.0.0.2, UDP
        send_a(32'h0A00_0002, 8'd17, 48'h0011_2233_4455, 8, 8'h01);
        expect_pend(8, 32'h0A00_0002, 8'd17, 48'h0011_2233_4455);
        run_tx(8, -1);

        // Back-to-back second packet; a sof during pend must not disturb it
        send_a(32'h0A00_0003, 8'd17, 48'h0066_7788_99AA, 4, 8'h11);
        expect_pend(4, 32'h0A00_0003, 8'd17, 48'h0066_7788_99AA);
        if_a.in_dst_ip = 32'hDEAD_BEEF;
        put_a(1'b1, 1'b1, 8'hEE);
        check("pend_sof_len", if_a.tx_pld_len, 4);
        check("pend_sof_dst", if_a.tx_dst_ip, 32'h0A00_0003);
        check("pend_sof_drop", if_a.drop, 0);
        run_tx(4, -1);

        // sof mid-fill after 3 bytes, then a 5-byte packet aborted at byte 2
        drops0 = drop_cnt_a;
        if_a.in_dst_ip = 32'h0A00_0004; if_a.in_proto = 8'd1;
        put_a(1'b1, 1'b0, 8'h21);
        put_a(1'b0, 1'b0, 8'h22);
        put_a(1'b0, 1'b0, 8'h23);
        check("fill_no_drop", if_a.drop, 0);
        send_a(32'h0A00_0005, 8'd6, 48'h0A0B_0C0D_0E0F, 5, 8'h31);
        expect_pend(5, 32'h0A00_0005, 8'd6, 48'h0A0B_0C0D_0E0F);
        check("restart_one_drop", drop_cnt_a - drops0, 1);
        run_tx(5, 2);

        // Reset during fill: silent abandon, id back to 0
        drops0 = drop_cnt_a;
        if_a.in_dst_ip = 32'h0A00_0006;
        put_a(1'b1, 1'b0, 8'h41);
        put_a(1'b0, 1'b0, 8'h42);
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_in_rdy", if_a.in_rdy, 1);
        check("mid_rst_tx_rdy", if_a.tx_rdy, 0);
        check("mid_rst_id", if_a.tx_id, 0);
        check("mid_rst_len", if_a.tx_pld_len, 0);
        rst = 1'b1;
        exp_id = 16'd0;
        exp_q.delete();
        @(negedge clk);
        check("mid_rst_no_drop", drop_cnt_a - drops0, 0);

        // 1-byte packet
        send_a(32'h0A00_0007, 8'd17, 48'h1122_3344_5566, 1, 8'hAA);
        expect_pend(1, 32'h0A00_0007, 8'd17, 48'h1122_3344_5566);
        run_tx(1, -1);

        // Small instance: 17 bytes overflow a 16-byte RAM
        if_b.in_dst_ip = 32'h0A00_0008; if_b.in_proto = 8'd17;
        for (int i = 0; i < 17; i++) begin
            put_b(i == 0, i == 16, 8'(i));
            if (i < 16) begin
                check("ovf_no_drop", if_b.drop, 0);
            end else begin
                check("ovf_drop", if_b.drop, 1);
                check("ovf_in_rdy", if_b.in_rdy, 1);
            end
            check("ovf_no_tx_rdy", if_b.tx_rdy, 0);
        end
        @(negedge clk);
        check("ovf_drop_pulse", if_b.drop, 0);
        check("ovf_idle_tx_rdy", if_b.tx_rdy, 0);

        // Exactly 16 bytes fit; abort while pending
        for (int i = 0; i < 16; i++) put_b(i == 0, i == 15, 8'(8'h80 + i));
        check("full_tx_rdy", if_b.tx_rdy, 1);
        check("full_len", if_b.tx_pld_len, 16);
        check("full_in_rdy", if_b.in_rdy, 0);
        check("full_no_drop", if_b.drop, 0);
        if_b.tx_done = 1'b1;
        @(negedge clk);
        if_b.tx_done = 1'b0;
        check("pend_abort_tx_rdy", if_b.tx_rdy, 0);
        check("pend_abort_in_rdy", if_b.in_rdy, 1);
        check("pend_abort_id", if_b.tx_id, 0);
        check("pend_abort_drop", if_b.drop, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
